// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle, MSB first,
// followed by a sign-fixup cycle. Fixed latency, start/busy/done handshake.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] dvd_q;     // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] part_rem;
  logic [WIDTH-1:0] raw_dvd;
  logic [CW-1:0]    count;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   trial, diff;

  always_comb begin
    a_neg = is_signed & dividend[WIDTH-1];
    b_neg = is_signed & divisor[WIDTH-1];
    // Negating -2^(WIDTH-1) yields the same bit pattern, which read unsigned is 2^(WIDTH-1).
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor  : divisor;
    trial = {part_rem, dvd_q[WIDTH-1]};
    diff  = trial - {1'b0, dvs_mag};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dvd_q     <= '0;
      dvs_mag   <= '0;
      part_rem  <= '0;
      raw_dvd   <= '0;
      count     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd_q    <= a_mag;
            dvs_mag  <= b_mag;
            raw_dvd  <= dividend;
            div_zero <= (divisor == '0);
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            part_rem <= '0;
            count    <= CW'(WIDTH);
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          // Top bit of the WIDTH+1-bit difference is the borrow: clear means trial >= divisor.
          if (!diff[WIDTH]) begin
            part_rem <= diff[WIDTH-1:0];
            dvd_q    <= {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            part_rem <= trial[WIDTH-1:0];
            dvd_q    <= {dvd_q[WIDTH-2:0], 1'b0};
          end
          count <= count - 1'b1;
          if (count == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (div_zero) begin
            quotient  <= '1;
            remainder <= raw_dvd;
          end else begin
            quotient  <= neg_q ? -dvd_q    : dvd_q;
            remainder <= neg_r ? -part_rem : part_rem;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, arithmetic reference model
// with random operands, and hand-written handshake/reset sequences.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic with truncation toward zero plus the two special cases.
  function automatic logic [63:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb, sq, sr;
    if (b == 0) return {{W{1'b1}}, a};
    if (!s) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sa = a;
    sb = b;
    sq = sa / sb;
    sr = sa % sb;
    return {sq, sr};
  endfunction

  // Presents a request at a negedge; returns at the negedge after the accepting edge
  // with start dropped and operands scrambled.
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    @(negedge clk);
    start     = 1'b0;
    is_signed = $urandom_range(0, 1);
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  // Waits (bounded) for done, counting cycles since the accepting edge and busy cycles,
  // and counting any cycle where the visible results drift from hold values.
  task automatic wait_done(input int lat0, output int lat, output int busy_cnt,
                           input logic [W-1:0] hq, input logic [W-1:0] hr, output int drift);
    lat = lat0;
    busy_cnt = 0;
    drift = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (quotient !== hq || remainder !== hr) drift++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic s, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [63:0] exp);
    int lat, bc, drift;
    logic [W-1:0] hq, hr;
    hq = quotient;
    hr = remainder;
    issue(s, a, b);
    wait_done(1, lat, bc, hq, hr, drift);
    check({name, " latency"}, lat, 34);
    check({name, " busy_cycles"}, bc, 33);
    check({name, " hold"}, drift, 0);
    check({name, " busy_at_done"}, busy, 0);
    check({name, " result"}, {quotient, remainder}, exp);
  endtask

  initial begin
    int lat, bc, drift, cnt;
    logic [W-1:0] q1, r1;
    logic s;
    logic [W-1:0] a, b;

    vecs = '{
      '{1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F},
      '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF},
      '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001},
      '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF},
      '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000},
      '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
      '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005},
      '{1'b0, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 32'h0000_0002},
      '{1'b0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005},
      '{1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFB},
      '{1'b0, 32'h0000_0003, 32'h0000_0007, 32'h0000_0000, 32'h0000_0003},
      '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000}
    };

    reset = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, quotient, remainder}, '0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      run_op($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, {vecs[i].q, vecs[i].r});

    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(0, 1);
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = $urandom_range(1, 16);
        2: b = -$urandom_range(1, 16);
        3: a = $urandom_range(0, 1000);
        default: ;
      endcase
      run_op($sformatf("rand%0d", i), s, a, b, model(s, a, b));
    end

    // Reset in the middle of CALC aborts with no later done pulse.
    issue(1'b0, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_outputs", {busy, done, quotient, remainder}, '0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("midreset_no_done", cnt, 0);
    run_op("after_reset", 1'b0, 32'd100, 32'd7, {32'd14, 32'd2});

    // start while busy is ignored, not queued.
    issue(1'b0, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    start = 1'b1;
    is_signed = 1'b1;
    dividend = 32'hFFFF_FF00;
    divisor = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(6, lat, bc, quotient, remainder, drift);
    check("busy_start latency", lat, 34);
    check("busy_start result", {quotient, remainder}, {32'd333, 32'd1});
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    check("busy_start not_queued", cnt, 0);

    // Back-to-back: start in the done cycle is accepted with no bubble.
    issue(1'b1, 32'hFFFF_FF9C, 32'd9);
    wait_done(1, lat, bc, quotient, remainder, drift);
    check("b2b first", {quotient, remainder}, model(1'b1, 32'hFFFF_FF9C, 32'd9));
    q1 = quotient;
    r1 = remainder;
    issue(1'b0, 32'd77, 32'd5);
    check("b2b busy_rises", busy, 1);
    wait_done(1, lat, bc, q1, r1, drift);
    check("b2b latency", lat, 34);
    check("b2b hold_first", drift, 0);
    check("b2b second", {quotient, remainder}, {32'd15, 32'd2});
    @(negedge clk);
    check("b2b done_one_cycle", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
